// File: rtl/fp_issue_ctrl.sv
// Single-outstanding FP issue/writeback controller sitting between the FP decoder and the FPU.
// Owns the FP register-file write port (FP loads take priority), sticky fflags and hung-FPU recovery.
module fp_issue_ctrl #(
    parameter int FLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            dec_valid_i,
    input  logic            dec_fpu_op_i,
    input  logic [4:0]      dec_rd_i,
    input  logic            dec_fp_wb_i,
    input  logic            dec_int_wb_i,
    output logic            stall_o,
    output logic            busy_o,

    output logic            fpu_in_valid_o,
    input  logic            fpu_in_ready_i,
    input  logic            fpu_out_valid_i,
    output logic            fpu_out_ready_o,
    input  logic [FLEN-1:0] fpu_result_i,
    input  logic [4:0]      fpu_status_i,
    output logic            fpu_flush_o,

    input  logic            load_wb_valid_i,
    input  logic [4:0]      load_wb_addr_i,
    input  logic [FLEN-1:0] load_wb_data_i,

    output logic            fp_rf_we_o,
    output logic [4:0]      fp_rf_waddr_o,
    output logic [FLEN-1:0] fp_rf_wdata_o,

    output logic            int_wb_valid_o,
    output logic [FLEN-1:0] int_wb_data_o,

    output logic [4:0]      fflags_o,
    input  logic            fflags_clr_i,
    output logic            timeout_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;

    // The counter only has to reach TIMEOUT_CYCLES-1 before EXEC is abandoned.
    localparam int              CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]      r_state;
    logic [4:0]      r_rd;
    logic            r_fp_wb;
    logic            r_int_wb;
    logic [FLEN-1:0] r_hold;
    logic [4:0]      r_fflags;
    logic            r_timeout;
    logic [CW-1:0]   r_cnt;
    logic            r_int_wb_valid;
    logic            r_flush;

    logic            w_capture;
    logic            w_fpu_write;

    assign w_capture   = (r_state == S_EXEC) && fpu_out_valid_i;
    assign w_fpu_write = (r_state == S_WB) && r_fp_wb && !load_wb_valid_i;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= S_IDLE;
            r_rd           <= '0;
            r_fp_wb        <= 1'b0;
            r_int_wb       <= 1'b0;
            r_hold         <= '0;
            r_timeout      <= 1'b0;
            r_cnt          <= '0;
            r_int_wb_valid <= 1'b0;
            r_flush        <= 1'b0;
        end else begin
            r_int_wb_valid <= 1'b0;
            r_flush        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (dec_valid_i && dec_fpu_op_i) begin
                        r_rd     <= dec_rd_i;
                        r_fp_wb  <= dec_fp_wb_i;
                        r_int_wb <= dec_int_wb_i;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (fpu_in_ready_i) begin
                        r_cnt   <= '0;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (fpu_out_valid_i) begin
                        r_hold  <= fpu_result_i;
                        r_state <= S_WB;
                    end else if (r_cnt == CNT_LAST) begin
                        r_flush   <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    // An FP result waits here while FP loads keep the write port busy.
                    if (r_fp_wb) begin
                        if (!load_wb_valid_i) begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_int_wb_valid <= r_int_wb;
                        r_state        <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // A clear coinciding with a capture keeps the new flags rather than dropping them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fflags <= '0;
        end else if (w_capture) begin
            r_fflags <= fflags_clr_i ? fpu_status_i : (r_fflags | fpu_status_i);
        end else if (fflags_clr_i) begin
            r_fflags <= '0;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        fp_rf_we_o    = 1'b0;
        fp_rf_waddr_o = '0;
        fp_rf_wdata_o = '0;
        if (load_wb_valid_i) begin
            fp_rf_we_o    = 1'b1;
            fp_rf_waddr_o = load_wb_addr_i;
            fp_rf_wdata_o = load_wb_data_i;
        end else if (w_fpu_write) begin
            fp_rf_we_o    = 1'b1;
            fp_rf_waddr_o = r_rd;
            fp_rf_wdata_o = r_hold;
        end
    end

    assign busy_o          = (r_state != S_IDLE);
    assign stall_o         = dec_valid_i && dec_fpu_op_i && (r_state != S_IDLE);
    assign fpu_in_valid_o  = (r_state == S_ISSUE);
    assign fpu_out_ready_o = (r_state == S_EXEC);
    assign fpu_flush_o     = r_flush;
    assign int_wb_valid_o  = r_int_wb_valid;
    assign int_wb_data_o   = r_hold;
    assign fflags_o        = r_fflags;
    assign timeout_o       = r_timeout;

endmodule
